// File: rtl/jtag_dbg_dreg_fifo.sv
// Purpose: JTAG debug data register (capture/shift chain) feeding a DEPTH-entry update FIFO toward the CPU debug unit.
// Latency: an Update-DR push is visible on REG_UPDATE/REG_Q one JTCK cycle after the push edge; a pop shows the next head one cycle later.
// Backpressure: the CPU drains with REG_UPDATE/REG_ACK; an update arriving on a full FIFO with no pop is dropped and flags OVERFLOW.
// Optional feature: define JTAG_DBG_DREG_PARITY_EN to add an even-parity bit at the chain MSB and reject bad-parity updates (PAR_ERR).
module jtag_dbg_dreg_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       JTCK,
    input  logic                       JRSTN,
    input  logic                       JTDI,
    output logic                       JTDO2,
    input  logic                       JSHIFT,
    input  logic                       JUPDATE,
    input  logic                       JCE2,
    input  logic                       JTAGREG_ENABLE,
    input  logic [DATA_W-1:0]          REG_D,
    input  logic [ADDR_W-1:0]          REG_ADDR_D,
    output logic [DATA_W-1:0]          REG_Q,
    output logic [ADDR_W-1:0]          REG_ADDR_Q,
    output logic                       REG_UPDATE,
    input  logic                       REG_ACK,
    output logic [$clog2(DEPTH):0]     FIFO_LEVEL,
    output logic                       OVERFLOW,
    input  logic                       OVF_CLR,
    output logic                       PAR_ERR
);

    localparam int L  = DATA_W + ADDR_W;
`ifdef JTAG_DBG_DREG_PARITY_EN
    localparam int CL = L + 1;
`else
    localparam int CL = L;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CL-1:0] sr_q, sr_d;
    logic          upd_q, upd_d;
    logic [L-1:0]  mem_q [DEPTH];
    logic [L-1:0]  mem_d [DEPTH];
    logic [LW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;

    logic          sel;
    logic          upd_pulse;
    logic          par_ok;
    logic [CL-1:0] cap_word;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic [L-1:0]  head;

    assign sel       = JTAGREG_ENABLE & JCE2;
    assign upd_d     = JUPDATE & JTAGREG_ENABLE;
    assign upd_pulse = upd_d & ~upd_q;

`ifdef JTAG_DBG_DREG_PARITY_EN
    logic par_err_q, par_err_d;
    // Parity bit sits above the address so it is the first bit shifted out.
    assign cap_word = {^{REG_ADDR_D, REG_D}, REG_ADDR_D, REG_D};
    assign par_ok   = ~(^sr_q);
    assign PAR_ERR  = par_err_q;
`else
    assign cap_word = {REG_ADDR_D, REG_D};
    assign par_ok   = 1'b1;
    assign PAR_ERR  = 1'b0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level    = wptr_q - rptr_q;
    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = REG_ACK & ~empty;
    assign push_req = upd_pulse & par_ok;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign head       = mem_q[rptr_q[AW-1:0]];
    assign REG_UPDATE = ~empty;
    assign REG_Q      = empty ? '0 : head[DATA_W-1:0];
    assign REG_ADDR_Q = empty ? '0 : head[L-1:DATA_W];
    assign FIFO_LEVEL = level;
    assign OVERFLOW   = ovf_q;
    assign JTDO2      = sr_q[CL-1];

    // Scan chain next state: capture when selected outside Shift-DR, shift MSB-out when in it.
    always_comb begin
        sr_d = sr_q;
        if (sel) begin
            if (JSHIFT) begin
                sr_d = {sr_q[CL-2:0], JTDI};
            end else begin
                sr_d = cap_word;
            end
        end
    end

    // FIFO storage, pointers and sticky overflow next state.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = sr_q[L-1:0];
            wptr_d                = wptr_q + LW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + LW'(1);
        end
        if (OVF_CLR) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; reset aborts any scan in progress and empties the FIFO.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            sr_q   <= '0;
            upd_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sr_q   <= sr_d;
            upd_q  <= upd_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            mem_q  <= mem_d;
        end
    end

`ifdef JTAG_DBG_DREG_PARITY_EN
    // Sticky parity error; only reset clears it.
    always_comb begin
        par_err_d = par_err_q;
        if (upd_pulse && !par_ok) begin
            par_err_d = 1'b1;
        end
    end

    // Parity error flag register.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

endmodule
